// File: rtl/display_pkg.sv
// Shared types and timing helpers for the runtime-programmable display timing generator.
package display_pkg;
  localparam int CORDW = 16;

  typedef logic [CORDW-2:0]        field_t;
  typedef logic signed [CORDW-1:0] coord_t;

  typedef struct packed {
    field_t res;
    field_t fp;
    field_t sync;
    field_t bp;
    logic   pol;
  } timing_cfg_t;

  typedef struct packed {
    coord_t sta;
    coord_t s_sta;
    coord_t s_end;
    coord_t a_end;
  } timing_drv_t;

  // Blanking sits at negative coordinates so the active area starts at 0.
  function automatic timing_drv_t derive_timing(input field_t res, input field_t fp,
                                                input field_t sync, input field_t bp);
    timing_drv_t d;
    d.sta   = -($signed({1'b0, fp}) + $signed({1'b0, sync}) + $signed({1'b0, bp}));
    d.s_sta = d.sta + $signed({1'b0, fp});
    d.s_end = d.s_sta + $signed({1'b0, sync});
    d.a_end = $signed({1'b0, res}) - coord_t'(1);
    return d;
  endfunction

  function automatic logic cfg_bad(input field_t res, input field_t fp,
                                   input field_t sync, input field_t bp);
    logic [CORDW+1:0] total;
    total = {3'b000, res} + {3'b000, fp} + {3'b000, sync} + {3'b000, bp};
    return (res == '0) || (sync == '0) || (total > {3'b000, {(CORDW-1){1'b1}}});
  endfunction
endpackage

// File: rtl/display_axis_ctr.sv
// One timing axis: position counter with start reload, wrap flag and sync/active compares.
module display_axis_ctr
  import display_pkg::*;
#(
  parameter coord_t RST_POS = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  coord_t      load_pos,
  input  timing_drv_t drv,
  output coord_t      pos,
  output logic        at_end,
  output logic        at_sta,
  output logic        sync_act,
  output logic        active
);
  coord_t pos_reg;

  // load_pos is the start value of the timing in force after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg <= RST_POS;
    end else if (load || (step && at_end)) begin
      pos_reg <= load_pos;
    end else if (step) begin
      pos_reg <= pos_reg + coord_t'(1);
    end
  end

  assign pos      = pos_reg;
  assign at_end   = (pos_reg == drv.a_end);
  assign at_sta   = (pos_reg == drv.sta);
  assign sync_act = (pos_reg >= drv.s_sta) && (pos_reg < drv.s_end);
  assign active   = !pos_reg[CORDW-1];
endmodule

// File: rtl/display_timing_prog.sv
// Programmable display timing generator: shadowed config, frame-aligned stop, frame counter.
module display_timing_prog
  import display_pkg::*;
#(
  parameter int CORDW     = display_pkg::CORDW,
  parameter int FCNTW     = 16,
  parameter int RST_H_RES = 640,
  parameter int RST_H_FP  = 16,
  parameter int RST_H_SYNC = 96,
  parameter int RST_H_BP  = 48,
  parameter int RST_V_RES = 480,
  parameter int RST_V_FP  = 10,
  parameter int RST_V_SYNC = 2,
  parameter int RST_V_BP  = 33,
  parameter bit RST_H_POL = 1'b0,
  parameter bit RST_V_POL = 1'b0
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CORDW-2:0]        cfg_h_res,
  input  logic [CORDW-2:0]        cfg_h_fp,
  input  logic [CORDW-2:0]        cfg_h_sync,
  input  logic [CORDW-2:0]        cfg_h_bp,
  input  logic [CORDW-2:0]        cfg_v_res,
  input  logic [CORDW-2:0]        cfg_v_fp,
  input  logic [CORDW-2:0]        cfg_v_sync,
  input  logic [CORDW-2:0]        cfg_v_bp,
  input  logic                    cfg_h_pol,
  input  logic                    cfg_v_pol,
  output logic                    cfg_err,
  output logic                    running,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [FCNTW-1:0]        frame_count
);
  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} run_state_t;

  localparam timing_cfg_t RST_H_CFG = '{res: field_t'(RST_H_RES), fp: field_t'(RST_H_FP),
                                        sync: field_t'(RST_H_SYNC), bp: field_t'(RST_H_BP), pol: RST_H_POL};
  localparam timing_cfg_t RST_V_CFG = '{res: field_t'(RST_V_RES), fp: field_t'(RST_V_FP),
                                        sync: field_t'(RST_V_SYNC), bp: field_t'(RST_V_BP), pol: RST_V_POL};
  localparam timing_cfg_t [1:0] RST_CFG = {RST_V_CFG, RST_H_CFG};
  localparam timing_drv_t [1:0] RST_DRV = {
    derive_timing(RST_V_CFG.res, RST_V_CFG.fp, RST_V_CFG.sync, RST_V_CFG.bp),
    derive_timing(RST_H_CFG.res, RST_H_CFG.fp, RST_H_CFG.sync, RST_H_CFG.bp)};

  run_state_t        state_reg, state_next;
  timing_cfg_t [1:0] cfg_in, shadow_reg;
  timing_drv_t [1:0] drv_reg, drv_next;
  logic [1:0]        pol_reg;
  logic              pending_reg, cfg_err_reg;
  logic [FCNTW-1:0]  fc_reg;
  coord_t [1:0]      pos;
  logic [1:0]        step, at_end, at_sta, sync_act, active;
  logic              counting, wrap, apply, offer, offer_bad;
  logic              hsync_reg, vsync_reg, de_reg, frame_reg, line_reg, running_reg;
  coord_t            sx_reg, sy_reg;

  assign cfg_in[0] = '{res: cfg_h_res, fp: cfg_h_fp, sync: cfg_h_sync, bp: cfg_h_bp, pol: cfg_h_pol};
  assign cfg_in[1] = '{res: cfg_v_res, fp: cfg_v_fp, sync: cfg_v_sync, bp: cfg_v_bp, pol: cfg_v_pol};

  assign counting  = (state_reg != ST_STOP);
  assign wrap      = counting && at_end[0] && at_end[1];
  // A pending config lands only where a frame boundary is guaranteed.
  assign apply     = pending_reg && (wrap || (state_reg == ST_STOP));
  assign offer     = cfg_valid && !pending_reg;
  assign offer_bad = cfg_bad(cfg_in[0].res, cfg_in[0].fp, cfg_in[0].sync, cfg_in[0].bp) ||
                     cfg_bad(cfg_in[1].res, cfg_in[1].fp, cfg_in[1].sync, cfg_in[1].bp);
  assign step      = {counting && at_end[0], counting};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      assign drv_next[gi] = apply ? derive_timing(shadow_reg[gi].res, shadow_reg[gi].fp,
                                                  shadow_reg[gi].sync, shadow_reg[gi].bp)
                                  : drv_reg[gi];
      display_axis_ctr #(.RST_POS(RST_DRV[gi].sta)) u_ctr (
        .clk      (clk_pix),
        .rst      (rst_pix),
        .step     (step[gi]),
        .load     (state_reg == ST_STOP),
        .load_pos (drv_next[gi].sta),
        .drv      (drv_reg[gi]),
        .pos      (pos[gi]),
        .at_end   (at_end[gi]),
        .at_sta   (at_sta[gi]),
        .sync_act (sync_act[gi]),
        .active   (active[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP:  if (en) state_next = ST_RUN;
      ST_RUN:   if (!en) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (en) state_next = ST_RUN;
        else if (wrap) state_next = ST_STOP;
      end
      default:  state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_reg   <= ST_STOP;
      shadow_reg  <= RST_CFG;
      drv_reg     <= RST_DRV;
      pol_reg     <= {RST_V_POL, RST_H_POL};
      pending_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
      fc_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cfg_err_reg <= offer && offer_bad;
      if (wrap) fc_reg <= fc_reg + 1'b1;
      if (apply) begin
        drv_reg     <= drv_next;
        pol_reg     <= {shadow_reg[1].pol, shadow_reg[0].pol};
        pending_reg <= 1'b0;
      end
      // offer requires !pending, so it can never coincide with apply.
      if (offer && !offer_bad) begin
        shadow_reg  <= cfg_in;
        pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      hsync_reg   <= ~RST_H_POL;
      vsync_reg   <= ~RST_V_POL;
      de_reg      <= 1'b0;
      frame_reg   <= 1'b0;
      line_reg    <= 1'b0;
      running_reg <= 1'b0;
      sx_reg      <= RST_DRV[0].sta;
      sy_reg      <= RST_DRV[1].sta;
    end else begin
      hsync_reg   <= ((counting && sync_act[0]) == pol_reg[0]);
      vsync_reg   <= ((counting && sync_act[1]) == pol_reg[1]);
      de_reg      <= counting && active[0] && active[1];
      line_reg    <= counting && at_sta[0];
      frame_reg   <= counting && at_sta[0] && at_sta[1];
      running_reg <= counting;
      sx_reg      <= pos[0];
      sy_reg      <= pos[1];
    end
  end

  assign cfg_ready   = !pending_reg;
  assign cfg_err     = cfg_err_reg;
  assign running     = running_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign frame       = frame_reg;
  assign line        = line_reg;
  assign sx          = sx_reg;
  assign sy          = sy_reg;
  assign frame_count = fc_reg;
endmodule

// File: doc/display_timing_prog.md
Name: display_timing_prog

Overview:
- Runtime-programmable successor to the fixed 640x480 display timing generator. Produces hsync, vsync, de, frame and line, plus signed sx/sy screen coordinates, for any mode described by a config word.
- Adds a start/stop control with frame-aligned stop, shadowed config loading via valid/ready, a config error check and a frame counter.
- Sits between the pixel-clock reset domain and the pattern/sprite renderers, replacing the fixed-mode generator.

Parameters:
- CORDW, 16, signed coordinate width; every cfg field is CORDW-1 bits, unsigned.
- FCNTW, 16, frame_count width.
- RST_H_RES/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timings loaded at reset.
- RST_V_RES/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timings loaded at reset.
- RST_H_POL, RST_V_POL, 0/0, sync polarity at reset (0 = negative).

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  asynchronous, active-high reset
- en  in  1  run request
- cfg_valid  in  1  new config offered
- cfg_ready  out  1  config can be accepted
- cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CORDW-1 each  horizontal timings
- cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CORDW-1 each  vertical timings
- cfg_h_pol, cfg_v_pol  in  1 each  sync polarity (1 = positive)
- cfg_err  out  1  one-cycle pulse: offered config rejected
- running  out  1  high in RUN or DRAIN
- hsync, vsync  out  1 each  syncs with programmed polarity
- de  out  1  data enable (active pixel)
- frame  out  1  one-cycle pulse at start of frame
- line  out  1  one-cycle pulse at start of line
- sx, sy  out  CORDW signed  screen position
- frame_count  out  FCNTW  number of completed frames, wraps

Behaviour:
- Reset (async assert, sync-released use):
  - Active config = RST_* values; no pending config.
  - State STOP; x = H_STA, y = V_STA.
  - Outputs: hsync/vsync = inactive level for the reset polarity; de = frame = line = 0; sx = H_STA, sy = V_STA; frame_count = 0; cfg_ready = 1; cfg_err = 0; running = 0.
- Derived values, computed when a config is applied and stored in registers (never recomputed per pixel), all CORDW signed:
  - H_STA = -(fp+sync+bp); HS_STA = H_STA+fp; HS_END = HS_STA+sync; HA_END = res-1.
  - Vertical values use the same formulas.
- Counting (RUN or DRAIN):
  - x increments every cycle.
  - At x == HA_END: x goes to H_STA, and y increments, or goes to V_STA when y == VA_END (frame wrap).
- Output latency: all outputs are registered, one cycle after the internal x/y.
  - hsync active when HS_STA <= x < HS_END; vsync uses the vertical values the same way.
  - de = (x >= 0 && y >= 0).
  - line = (x == H_STA); frame = (x == H_STA && y == V_STA).
  - sx/sy = delayed x/y.
- State machine:
  - STOP: counters held at H_STA/V_STA; syncs inactive; de = frame = line = 0. en = 1 moves to RUN next cycle; the first RUN cycle has x = H_STA, y = V_STA, so frame pulses one cycle later.
  - RUN: en = 0 moves to DRAIN.
  - DRAIN: keeps counting. en = 1 returns to RUN. At the frame wrap, goes to STOP with counters at the start values; no partial frame is ever emitted.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready. The fields are captured into the shadow register and pending = 1.
  - cfg_ready = !pending.
  - Rejected, no capture, cfg_err pulses the next cycle: any res == 0, any sync == 0, or fp+sync+bp+res > 2^(CORDW-1)-1 for either axis.
- Config apply:
  - Pending is applied at the frame wrap (same edge where x,y return to start), or on the first cycle in STOP.
  - Derived values update on that edge and pending clears.
  - The frame pulse after a mode change reflects the new timings; a frame never mixes old and new timings.
- Simultaneous events:
  - A transfer on the same edge as an apply is captured after the apply; it stays pending for the next wrap.
  - A wrap in DRAIN with pending set applies the config, then enters STOP.
- frame_count increments on every frame wrap in RUN/DRAIN (not on STOP entry from reset), and wraps modulo 2^FCNTW.
- Reset mid-operation: immediate return to the reset state; pending config is discarded.

Decomposition:
- Package display_pkg:
  - CORDW default;
  - struct timing_cfg_t {res, fp, sync, bp, pol};
  - struct timing_drv_t {sta, s_sta, s_end, a_end};
  - function derive_timing().
- Sub-module display_axis_ctr, instantiated twice (H and V): counter, wrap flag, sync/active compare.

Test Plan:
- Reset defaults, en = 1: hsync low for 96 cycles per 800-cycle line; vsync low for 2 lines of 525; de high for 640x480 pixels per frame; frame period 420000 cycles; first frame pulse 2 cycles after en.
- Mid-frame config of 4x2 active, fp/sync/bp 1/1/1 horizontal and 1/1/1 vertical, positive polarity: cfg_ready drops; current 640x480 frame completes unchanged; next frame is 7x5 cycles with H_STA = -3, hsync high at x = -2, frame period 35.
- en = 0 at y = 100: DRAIN continues to the frame end, then STOP with sx = -160, sy = -45, de = 0, running = 0; frame_count +1. Re-assert en during DRAIN: no gap, frame pulses on schedule.
- Config with cfg_h_sync = 0: no capture, cfg_err = 1 for exactly one cycle, cfg_ready stays 1, timings unchanged.
- Second cfg_valid while pending: not accepted (cfg_ready = 0). Accepted on the cycle after the apply edge, and applied one frame later.
- rst_pix asserted asynchronously mid-line with a pending config: outputs take reset values without a clock edge; after release the 640x480 timings resume and the pending config is lost.
